lpc_capture_sched: RTL and testbench

- Queues the 32-bit LPC cycle records produced by the LPC peripheral (TDATA/READY) and drains them to a downstream consumer over a valid/ready stream.
- Filters records by cycle type and I/O address window; counts records dropped on overflow.
- Enable/drain FSM gives software a clean start/stop of capture without truncating queued records.
- Sits between lpc_periph and the host-facing transport (UART/USB bridge).

---
 rtl/lpc_capture_sched_pkg.sv | 32 +++
 rtl/lpc_sync_fifo.sv | 46 ++++
 rtl/lpc_capture_sched.sv | 92 +++++++++
 tb/tb_lpc_capture_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lpc_capture_sched_pkg.sv
// Shared definitions for the LPC capture scheduler: record layout, cycle codes,
// FSM encodings and the address-window helper.
package lpc_capture_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'b00,
        SCHED_RUN   = 2'b01,
        SCHED_DRAIN = 2'b10,
        SCHED_BAD   = 2'b11
    } sched_state_e;

    localparam logic [1:0] CYC_NONE = 2'b00;
    localparam logic [1:0] CYC_WR   = 2'b01;
    localparam logic [1:0] CYC_RD   = 2'b11;

    // Record as delivered by lpc_periph: addr [27:12], data [11:4], type [1:0]
    typedef struct packed {
        logic [3:0]  rsvd_hi;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [1:0]  rsvd_lo;
        logic [1:0]  cyc;
    } lpc_rec_t;

    // lo > hi disables the window so every address passes
    function automatic logic addr_pass(input logic [15:0] addr,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (lo > hi) || ((addr >= lo) && (addr <= hi));
    endfunction

endpackage

// File: rtl/lpc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is taken only
// when a pop frees a slot on the same edge.
module lpc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 32
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/lpc_capture_sched.sv
// Captures LPC cycle records on READY rising edges, filters them by type and
// address window, queues them and drains them over a valid/ready stream.
module lpc_capture_sched
    import lpc_capture_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic [31:0]   rec_i,
    input  logic          rec_rdy_i,
    input  logic          cfg_en_i,
    input  logic          cfg_drop_rd_i,
    input  logic          cfg_drop_wr_i,
    input  logic [15:0]   cfg_addr_lo_i,
    input  logic [15:0]   cfg_addr_hi_i,
    input  logic          ovf_clr_i,
    output logic [31:0]   m_tdata_o,
    output logic          m_tvalid_o,
    input  logic          m_tready_i,
    output logic [AW:0]   level_o,
    output logic [15:0]   ovf_cnt_o,
    output logic [1:0]    state_o,
    output logic          busy_o
);

    sched_state_e state, state_nxt;
    lpc_rec_t     rec;
    logic         rec_rdy_q;
    logic         offer, accept, pop, ovf_evt;
    logic         fifo_full, fifo_empty;

    assign rec   = lpc_rec_t'(rec_i);
    assign offer = rec_rdy_i & ~rec_rdy_q;

    assign accept = offer && (state == SCHED_RUN)
                    && (rec.cyc != CYC_NONE)
                    && !((rec.cyc == CYC_RD) && cfg_drop_rd_i)
                    && !((rec.cyc == CYC_WR) && cfg_drop_wr_i)
                    && addr_pass(rec.addr, cfg_addr_lo_i, cfg_addr_hi_i);

    assign pop     = m_tvalid_o & m_tready_i;
    assign ovf_evt = accept & fifo_full & ~pop;

    lpc_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(32)) u_fifo (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .push   (accept),
        .din    (rec_i),
        .pop    (pop),
        .dout   (m_tdata_o),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level_o)
    );

    assign m_tvalid_o = ~fifo_empty;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            rec_rdy_q <= 1'b0;
            ovf_cnt_o <= '0;
            state     <= SCHED_IDLE;
        end else begin
            rec_rdy_q <= rec_rdy_i;
            state     <= state_nxt;
            // clear takes priority over a coincident overflow
            if (ovf_clr_i)
                ovf_cnt_o <= '0;
            else if (ovf_evt && ovf_cnt_o != 16'hFFFF)
                ovf_cnt_o <= ovf_cnt_o + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCHED_IDLE:  if (cfg_en_i) state_nxt = SCHED_RUN;
            SCHED_RUN:   if (!cfg_en_i) state_nxt = SCHED_DRAIN;
            SCHED_DRAIN: begin
                if (cfg_en_i)             state_nxt = SCHED_RUN;
                else if (level_o == '0)   state_nxt = SCHED_IDLE;
            end
            default:     state_nxt = SCHED_IDLE;
        endcase
    end

    assign state_o = state;
    assign busy_o  = (state != SCHED_IDLE) || (level_o != '0);

endmodule

// File: tb/tb_lpc_capture_sched.sv
// Directed bench for lpc_capture_sched: filtering, FWFT latency, overflow,
// drain FSM and asynchronous reset.
module tb_lpc_capture_sched;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic [31:0] rec_i;
    logic        rec_rdy_i, cfg_en_i, cfg_drop_rd_i, cfg_drop_wr_i;
    logic [15:0] cfg_addr_lo_i, cfg_addr_hi_i;
    logic        ovf_clr_i, m_tready_i;
    logic [31:0] m_tdata_o;
    logic        m_tvalid_o;
    logic [4:0]  level_o;
    logic [15:0] ovf_cnt_o;
    logic [1:0]  state_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    lpc_capture_sched #(.DEPTH(16), .AW(4)) dut (
        .clk_i(clk_i), .nrst_i(nrst_i), .rec_i(rec_i), .rec_rdy_i(rec_rdy_i),
        .cfg_en_i(cfg_en_i), .cfg_drop_rd_i(cfg_drop_rd_i), .cfg_drop_wr_i(cfg_drop_wr_i),
        .cfg_addr_lo_i(cfg_addr_lo_i), .cfg_addr_hi_i(cfg_addr_hi_i), .ovf_clr_i(ovf_clr_i),
        .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .level_o(level_o), .ovf_cnt_o(ovf_cnt_o), .state_o(state_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mk(input logic [15:0] a, input logic [7:0] d,
                                       input logic [1:0] t);
        return {4'h0, a, d, 2'b00, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // READY held two cycles, as lpc_periph does
    task automatic offer(input logic [31:0] r);
        rec_i = r;
        rec_rdy_i = 1'b1;
        tick();
        tick();
        rec_rdy_i = 1'b0;
        tick();
    endtask

    logic [31:0] exp_q [$];

    initial begin
        nrst_i = 1'b0; rec_i = '0; rec_rdy_i = 0; cfg_en_i = 0;
        cfg_drop_rd_i = 0; cfg_drop_wr_i = 0;
        cfg_addr_lo_i = 16'h0100; cfg_addr_hi_i = 16'h0000;
        ovf_clr_i = 0; m_tready_i = 0;
        @(negedge clk_i);
        chk("rst_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("rst_tdata",  m_tdata_o, 32'd0);
        chk("rst_level",  32'(level_o), 32'd0);
        chk("rst_ovf",    32'(ovf_cnt_o), 32'd0);
        chk("rst_state",  32'(state_o), 32'd0);
        chk("rst_busy",   32'(busy_o), 32'd0);
        nrst_i = 1'b1;
        tick();

        // basic capture, single beat from a held READY
        cfg_en_i = 1'b1;
        tick();
        chk("run_state", 32'(state_o), 32'd1);
        m_tready_i = 1'b1;
        rec_i = mk(16'h0080, 8'hA5, 2'b01);
        rec_rdy_i = 1'b1;
        tick();
        chk("lat_tvalid", 32'(m_tvalid_o), 32'd1);
        chk("lat_tdata",  m_tdata_o, 32'h00080A51);
        tick();
        rec_rdy_i = 1'b0;
        chk("one_beat_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("one_beat_level",  32'(level_o), 32'd0);
        chk("one_beat_ovf",    32'(ovf_cnt_o), 32'd0);
        tick();

        // drop reads
        m_tready_i = 1'b0;
        cfg_drop_rd_i = 1'b1;
        offer(mk(16'h0060, 8'h11, 2'b11));
        chk("droprd_level", 32'(level_o), 32'd0);
        offer(mk(16'h0060, 8'h22, 2'b01));
        chk("droprd_level_wr", 32'(level_o), 32'd1);
        chk("droprd_tdata", m_tdata_o, mk(16'h0060, 8'h22, 2'b01));
        m_tready_i = 1'b1;
        tick();
        chk("droprd_drained", 32'(level_o), 32'd0);
        m_tready_i = 1'b0;
        cfg_drop_rd_i = 1'b0;

        // address window, then disabled window
        cfg_addr_lo_i = 16'h0080; cfg_addr_hi_i = 16'h0080;
        offer(mk(16'h007F, 8'h01, 2'b01));
        offer(mk(16'h0080, 8'h02, 2'b01));
        offer(mk(16'h0081, 8'h03, 2'b01));
        chk("win_level", 32'(level_o), 32'd1);
        chk("win_tdata", m_tdata_o, mk(16'h0080, 8'h02, 2'b01));
        cfg_addr_lo_i = 16'h0100; cfg_addr_hi_i = 16'h0000;
        offer(mk(16'h007F, 8'h04, 2'b01));
        offer(mk(16'h0080, 8'h05, 2'b01));
        offer(mk(16'h0081, 8'h06, 2'b01));
        chk("nowin_level", 32'(level_o), 32'd4);
        exp_q = '{mk(16'h0080, 8'h02, 2'b01), mk(16'h007F, 8'h04, 2'b01),
                  mk(16'h0080, 8'h05, 2'b01), mk(16'h0081, 8'h06, 2'b01)};
        m_tready_i = 1'b1;
        foreach (exp_q[i]) begin
            chk($sformatf("win_beat%0d", i), m_tdata_o, exp_q[i]);
            tick();
        end
        chk("win_empty", 32'(m_tvalid_o), 32'd0);
        m_tready_i = 1'b0;

        // overflow: 20 offers into 16 entries
        for (int i = 0; i < 20; i++) offer(mk(16'h0200, 8'(i), 2'b11));
        chk("full_level", 32'(level_o), 32'd16);
        chk("full_ovf",   32'(ovf_cnt_o), 32'd4);
        // full with simultaneous pop: push taken, level unchanged
        rec_i = mk(16'h0200, 8'hEE, 2'b11);
        rec_rdy_i = 1'b1;
        m_tready_i = 1'b1;
        tick();
        m_tready_i = 1'b0;
        rec_rdy_i = 1'b0;
        chk("fullpop_level", 32'(level_o), 32'd16);
        chk("fullpop_ovf",   32'(ovf_cnt_o), 32'd4);
        tick();
        m_tready_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("ovf_beat%0d", i), m_tdata_o, mk(16'h0200, 8'(i), 2'b11));
            tick();
        end
        chk("ovf_beat_last", m_tdata_o, mk(16'h0200, 8'hEE, 2'b11));
        tick();
        chk("ovf_drained", 32'(level_o), 32'd0);
        m_tready_i = 1'b0;
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_clr", 32'(ovf_cnt_o), 32'd0);

        // drain FSM
        for (int i = 0; i < 3; i++) offer(mk(16'h0300, 8'(8'h30 + i), 2'b01));
        cfg_en_i = 1'b0;
        tick();
        chk("drain_state", 32'(state_o), 32'd2);
        offer(mk(16'h0300, 8'h3F, 2'b01));
        chk("drain_noq", 32'(level_o), 32'd3);
        chk("drain_busy", 32'(busy_o), 32'd1);
        m_tready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain_beat%0d", i), m_tdata_o, mk(16'h0300, 8'(8'h30 + i), 2'b01));
            tick();
        end
        chk("drain_level", 32'(level_o), 32'd0);
        tick();
        chk("drain_idle", 32'(state_o), 32'd0);
        chk("drain_notbusy", 32'(busy_o), 32'd0);

        // async reset mid-operation
        m_tready_i = 1'b0;
        cfg_en_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) offer(mk(16'h0400, 8'(i), 2'b01));
        chk("pre_rst_level", 32'(level_o), 32'd8);
        nrst_i = 1'b0;
        #1;
        chk("arst_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("arst_level",  32'(level_o), 32'd0);
        chk("arst_state",  32'(state_o), 32'd0);
        @(negedge clk_i);
        nrst_i = 1'b1;
        tick();
        chk("post_rst_run", 32'(state_o), 32'd1);
        chk("post_rst_tvalid", 32'(m_tvalid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
